// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch PC unit: FSM state encoding,
// datapath widths and the sequential PC increment.
package fetch_pkg;
  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_INC = 64'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register with synchronous active-low reset to RESET_PC,
// a load enable, and the modulo-2^64 +4 incrementer feeding the next-PC mux.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_val,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end
  end

  assign o_pc       = r_pc;
  // Carry out of bit 63 is dropped on purpose: the PC wraps to zero.
  assign o_pc_plus4 = r_pc + PC_INC;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch sequencer: IDLE -> REQ -> WAIT -> EXEC -> REQ, one instruction in flight.
// Macro FETCH_ALIGN_CHECK_EN: misaligned commit traps in FAULT instead of masking low PC bits.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [XLEN-1:0]    i_next_pc,
  input  logic               i_commit,
  input  logic               i_stall,
  output logic [XLEN-1:0]    o_pc,
  output logic [XLEN-1:0]    o_pc_plus4,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [XLEN-1:0]    o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_misalign_fault
);
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~64'd3;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic               w_req_valid;
  logic               w_fault;
  logic               w_commit_go;
  logic               w_rsp_take;
  logic               w_misalign;
  logic [XLEN-1:0]    w_pc;
  logic [XLEN-1:0]    w_pc_load_val;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;

  assign w_commit_go = (r_state == ST_EXEC) && i_commit && !i_stall;
  assign w_rsp_take  = (r_state == ST_WAIT) && i_imem_rsp_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign    = |i_next_pc[1:0];
  assign w_pc_load_val = i_next_pc;
`else
  assign w_misalign    = 1'b0;
  assign w_pc_load_val = i_next_pc & PC_ALIGN_MASK;
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_commit_go),
    .i_load_val (w_pc_load_val),
    .o_pc       (w_pc),
    .o_pc_plus4 (o_pc_plus4)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_REQ;
      ST_REQ: begin
        w_req_valid = 1'b1;
        if (i_imem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (i_imem_rsp_valid) w_state_nxt = ST_EXEC;
      ST_EXEC:  if (w_commit_go) w_state_nxt = w_misalign ? ST_FAULT : ST_REQ;
      ST_FAULT: w_fault = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Responses only count in WAIT, so stale beats after reset are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_rsp_take) begin
      r_instr       <= i_imem_rsp_data;
      r_instr_valid <= 1'b1;
    end else if (w_commit_go) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign o_pc             = w_pc;
  assign o_imem_req_addr  = w_pc;
  assign o_imem_req_valid = w_req_valid;
  assign o_instr          = r_instr;
  assign o_instr_valid    = r_instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign o_misalign_fault = w_fault;
`else
  assign o_misalign_fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit; a second instance starts at the top of memory.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset_n, commit, stall, req_ready, rsp_valid;
  logic [63:0] next_pc;
  logic [31:0] rsp_data;
  logic [63:0] pc, pc_plus4, req_addr;
  logic        req_valid, instr_valid, fault;
  logic [31:0] instr;

  logic        w_reset_n, w_commit, w_stall, w_req_ready, w_rsp_valid;
  logic [63:0] w_next_pc;
  logic [31:0] w_rsp_data;
  logic [63:0] w_pc, w_pc_plus4, w_req_addr;
  logic        w_req_valid, w_instr_valid, w_fault;
  logic [31:0] w_instr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_next_pc(next_pc), .i_commit(commit),
    .i_stall(stall), .o_pc(pc), .o_pc_plus4(pc_plus4),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready),
    .o_imem_req_addr(req_addr), .i_imem_rsp_valid(rsp_valid),
    .i_imem_rsp_data(rsp_data), .o_instr(instr), .o_instr_valid(instr_valid),
    .o_misalign_fault(fault)
  );

  fetch_pc_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .i_clk(clk), .i_reset_n(w_reset_n), .i_next_pc(w_next_pc), .i_commit(w_commit),
    .i_stall(w_stall), .o_pc(w_pc), .o_pc_plus4(w_pc_plus4),
    .o_imem_req_valid(w_req_valid), .i_imem_req_ready(w_req_ready),
    .o_imem_req_addr(w_req_addr), .i_imem_rsp_valid(w_rsp_valid),
    .i_imem_rsp_data(w_rsp_data), .o_instr(w_instr), .o_instr_valid(w_instr_valid),
    .o_misalign_fault(w_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pc"}, pc, 64'h0);
    check({tag, "_pc4"}, pc_plus4, 64'h4);
    check({tag, "_reqv"}, 64'(req_valid), 64'h0);
    check({tag, "_addr"}, req_addr, 64'h0);
    check({tag, "_instr"}, 64'(instr), 64'h0);
    check({tag, "_iv"}, 64'(instr_valid), 64'h0);
    check({tag, "_flt"}, 64'(fault), 64'h0);
  endtask

  // Waits (bounded) for a request, then accepts it and returns the response word.
  task automatic fetch_one(input string tag, input logic [63:0] exp_addr, input logic [31:0] data);
    for (int i = 0; i < 8 && !req_valid; i++) tick();
    check({tag, "_reqv"}, 64'(req_valid), 64'h1);
    check({tag, "_addr"}, req_addr, exp_addr);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
    check({tag, "_instr"}, 64'(instr), 64'(data));
    check({tag, "_iv"}, 64'(instr_valid), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_pc, np, exp_new;
    logic [31:0] d;
    int          wait_n, stall_n;

    reset_n = 1'b0; commit = 1'b0; stall = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; next_pc = '0; rsp_data = '0;
    w_reset_n = 1'b0; w_commit = 1'b0; w_stall = 1'b0; w_req_ready = 1'b0;
    w_rsp_valid = 1'b0; w_next_pc = '0; w_rsp_data = '0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("rst");
    end
    reset_n = 1'b1;
    tick();
    check("rel_reqv", 64'(req_valid), 64'h1);
    check("rel_addr", req_addr, 64'h0);

    // Ready held low: request stays put.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_reqv", 64'(req_valid), 64'h1);
      check("hold_addr", req_addr, 64'h0);
    end
    // Accept with a same-cycle response, which must be ignored.
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b0;
    check("acc_reqv", 64'(req_valid), 64'h0);
    check("acc_iv", 64'(instr_valid), 64'h0);
    tick();
    check("wait_iv", 64'(instr_valid), 64'h0);
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    tick();
    rsp_valid = 1'b0;
    check("seq_instr", 64'(instr), 64'h13);
    check("seq_iv", 64'(instr_valid), 64'h1);
    check("seq_pc4", pc_plus4, 64'h4);
    commit = 1'b1; next_pc = 64'h4;
    tick();
    commit = 1'b0;
    check("seq_pc", pc, 64'h4);
    check("seq_iv_clr", 64'(instr_valid), 64'h0);
    check("seq_reqv", 64'(req_valid), 64'h1);
    check("seq_addr", req_addr, 64'h4);

    // Stall blocks commit; then branch to 0x1000.
    fetch_one("stb", 64'h4, 32'h1234_5678);
    commit = 1'b1; stall = 1'b1; next_pc = 64'h1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 64'h4);
      check("stall_iv", 64'(instr_valid), 64'h1);
      check("stall_reqv", 64'(req_valid), 64'h0);
    end
    stall = 1'b0;
    tick();
    commit = 1'b0;
    check("br_pc", pc, 64'h1000);
    check("br_reqv", 64'(req_valid), 64'h1);
    check("br_addr", req_addr, 64'h1000);

    // Misaligned commit.
    fetch_one("mis", 64'h1000, 32'h0000_0067);
    commit = 1'b1; next_pc = 64'h1002;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flt", 64'(fault), 64'h1);
    check("mis_pc", pc, 64'h1002);
    check("mis_iv", 64'(instr_valid), 64'h0);
    req_ready = 1'b1; rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flt_sticky", 64'(fault), 64'h1);
      check("flt_noreq", 64'(req_valid), 64'h0);
      check("flt_iv", 64'(instr_valid), 64'h0);
    end
    req_ready = 1'b0; rsp_valid = 1'b0;
`else
    check("mis_flt", 64'(fault), 64'h0);
    check("mis_pc", pc, 64'h1000);
    check("mis_reqv", 64'(req_valid), 64'h1);
    check("mis_addr", req_addr, 64'h1000);
`endif
    commit = 1'b0;
    reset_n = 1'b0;
    tick();
    check_idle_outputs("mis_rst");
    reset_n = 1'b1;
    tick();

    // Reset while waiting, then a stale response after release.
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    check_idle_outputs("midrst");
    reset_n = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hBAD0_0BAD;
    tick();
    check("stale_iv0", 64'(instr_valid), 64'h0);
    tick();
    check("stale_iv1", 64'(instr_valid), 64'h0);
    check("stale_reqv", 64'(req_valid), 64'h1);
    check("stale_addr", req_addr, 64'h0);
    rsp_valid = 1'b0;

    // Wrap instance: top-of-memory PC rolls over to zero.
    tick();
    check("wrap_rst_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", w_pc_plus4, 64'h0);
    w_reset_n = 1'b1; w_req_ready = 1'b1;
    tick();
    check("wrap_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = 32'h0000_0013;
    tick();
    w_rsp_valid = 1'b0;
    check("wrap_iv", 64'(w_instr_valid), 64'h1);
    w_commit = 1'b1; w_next_pc = 64'h0;
    tick();
    w_commit = 1'b0;
    check("wrap_pc", w_pc, 64'h0);
    check("wrap_flt", 64'(w_fault), 64'h0);
    check("wrap_reqv", 64'(w_req_valid), 64'h1);

    // Randomized fetch/commit stream against a transaction-level PC model.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_pc = 64'h0;
    for (int it = 0; it < 40; it++) begin
      wait_n = $urandom_range(0, 3);
      for (int i = 0; i < wait_n; i++) begin
        tick();
        check("rnd_hold_addr", req_addr, exp_pc);
      end
      d = $urandom;
      fetch_one("rnd", exp_pc, d);
      check("rnd_pc4", pc_plus4, exp_pc + 64'd4);
      stall_n = $urandom_range(0, 2);
      stall = 1'b1;
      for (int i = 0; i < stall_n; i++) begin
        commit = 1'($urandom_range(0, 1));
        next_pc = {$urandom, $urandom};
        tick();
        check("rnd_stall_pc", pc, exp_pc);
      end
      stall = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        np = exp_pc + 64'd4;
      end else begin
        np = {$urandom, $urandom};
`ifdef FETCH_ALIGN_CHECK_EN
        np = np - (np % 64'd4);
`endif
      end
      exp_new = np - (np % 64'd4);
      next_pc = np; commit = 1'b1;
      tick();
      commit = 1'b0;
      exp_pc = exp_new;
      check("rnd_pc", pc, exp_pc);
      check("rnd_iv_clr", 64'(instr_valid), 64'h0);
      check("rnd_flt", 64'(fault), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
